audio_dac_serializer: RTL
=========================

# audio_dac_serializer

Transmit half of the audio codec link. It accepts stereo sample pairs from the user circuit through the same `write`/`write_ready` handshake the codec interface exposes, and buffers them in a small FIFO. It shifts them out MSB-first on `AUD_DACDAT` in left-justified format, timed by the codec-mastered `AUD_BCLK` and `AUD_DACLRCK`. It sits between the user circuit and the codec pins, alongside the ADC receive path, in the `CLOCK_50` domain.

## Interface

Parameters:
- `DATA_WIDTH`, 24: bits per channel sample.
- `FIFO_AW`, 3: FIFO address width; depth = 2^FIFO_AW stereo frames (8).

Ports:
- `CLOCK_50`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `write`  in  1  push request; accepted only when `write_ready`=1.
- `writedata_left`  in  DATA_WIDTH  left sample, two's complement.
- `writedata_right`  in  DATA_WIDTH  right sample, two's complement.
- `write_ready`  out  1  FIFO not full.
- `AUD_BCLK`  in  1  codec bit clock, asynchronous to `CLOCK_50`.
- `AUD_DACLRCK`  in  1  codec DAC frame clock: high = left, low = right.
- `AUD_DACDAT`  out  1  serial DAC data.
- `fifo_used`  out  FIFO_AW+1  frames currently stored (0..2^FIFO_AW).
- `underflow`  out  1  sticky flag, set when a frame is due and the FIFO is empty.

## Operation

- Synchronizers: `AUD_BCLK` and `AUD_DACLRCK` each pass through 2 flops plus 1 history flop.
  - `bclk_fall` = history 1, stage-2 0.
  - `lrck_rise` = history 0, stage-2 1; `lrck_fall` = history 1, stage-2 0.
- FIFO: 2^FIFO_AW entries of 2×DATA_WIDTH bits.
  - `write_ready` = !full, from registered state.
  - A push occurs on `write && write_ready`; `write` while full is ignored and changes no state.
  - Push and pop in the same cycle: both happen, `fifo_used` unchanged, pointers wrap modulo 2^FIFO_AW.
- State machine: WAIT_SYNC, LEFT, RIGHT.
  - WAIT_SYNC (after reset): `AUD_DACDAT`=0. Every `lrck_fall` and `bclk_fall` is ignored. Leave only on `lrck_rise`.
  - On `lrck_rise` (from any state), go to LEFT. If FIFO non-empty: pop, load the shift register with left, latch right into `hold_r`. If empty: load zeros into both, set `underflow`.
  - On `lrck_fall` in LEFT, go to RIGHT and load the shift register from `hold_r`. `lrck_fall` in RIGHT or WAIT_SYNC is ignored.
  - On load, `AUD_DACDAT` = MSB of the loaded word; the bit counter is set to DATA_WIDTH-1.
  - On each `bclk_fall` while the counter > 0: shift left, fill 0, decrement. When the counter = 0, `AUD_DACDAT` holds 0 for the rest of the half-frame (extra BCLKs send zeros).
  - `lrck_*` and `bclk_fall` in the same cycle: the LRCK load wins and that BCLK edge does not shift.
- `underflow` is cleared only by `reset`.
- Reset mid-frame:
  - Within one cycle: FIFO emptied, `fifo_used`=0, `underflow`=0, state WAIT_SYNC, `AUD_DACDAT`=0.
  - The partial frame is abandoned; output resumes at the next `lrck_rise`, never mid-channel.

## Timing

- Reset values: `write_ready`=1, `fifo_used`=0, `underflow`=0, `AUD_DACDAT`=0.
- Pin-to-output latency:
  - A level change on `AUD_DACLRCK`/`AUD_BCLK` first sampled at `CLOCK_50` edge k raises the detect at edge k+1.
  - `AUD_DACDAT` updates at edge k+2, and is registered (no combinational path from pins).
  - Requires BCLK high/low times ≥ 3 `CLOCK_50` periods (true at 48 kHz, BCLK ≤ 3.072 MHz).
- `fifo_used` and `write_ready` update the cycle after a push/pop.
  - Full after 8 accepted writes with no pop: `write_ready`=0 from the following cycle.
- Sustained throughput: one frame per LRCK period; FIFO pops only at `lrck_rise`.

## Test plan

- Reset, then BCLK period 16 cycles with 32 BCLKs per half-frame; push (L=0xA5A5A5, R=0x5A5A5A) before the first `lrck_rise`.
  - Left slot carries 24 bits 0xA5A5A5 MSB-first, then 8 zeros; right slot 0x5A5A5A, then zeros.
  - `fifo_used` goes 1→0 at the pop.
- Push 9 frames back-to-back with LRCK held low.
  - `write_ready` falls after the 8th; the 9th is ignored and `fifo_used`=8.
  - The output sequence later shows frames 1..8 in order.
- LRCK running with the FIFO empty: `AUD_DACDAT` stays 0 and `underflow`=1 after the first `lrck_rise`.
  - A subsequent push plays correctly at the next `lrck_rise`; `underflow` stays 1.
- Reset pulse asserted in the middle of a left half-frame (bit 10 of 24).
  - `AUD_DACDAT`=0 the next cycle and `fifo_used`=0.
  - No output until the next `lrck_rise`; no partial right channel is sent.
- With FIFO at 8, assert `write` in the same cycle as the pop at `lrck_rise`.
  - The pop occurs and the write is refused, because `write_ready` was 0 that cycle; `fifo_used` becomes 7.
- Start stimulus with DACLRCK already low mid-frame.
  - The block stays in WAIT_SYNC, ignores `lrck_fall`, and the first transmitted bits align to the first `lrck_rise`.

Source files
------------

// File: rtl/audio_dac_serializer.sv
// Transmit half of the audio codec link: buffers stereo frames in a small FIFO and
// shifts them out left-justified, MSB first, on the codec-mastered BCLK/DACLRCK.
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_AW    = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata_left,
    input  logic [DATA_WIDTH-1:0] writedata_right,
    output logic                  write_ready,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic [FIFO_AW:0]      fifo_used,
    output logic                  underflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FW    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   ONE_CNT  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] ONE_PTR  = FIFO_AW'(1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]   ONE_BIT  = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } state_t;

    // Index 0 = BCLK, index 1 = DACLRCK. Each: two sync stages plus one history flop.
    logic [1:0] pin_in;
    logic [1:0] pin_rise;
    logic [1:0] pin_fall;

    assign pin_in = {AUD_DACLRCK, AUD_BCLK};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [2:0] sync_q;
            logic [2:0] sync_d;

            always_comb begin
                sync_d = {sync_q[1:0], pin_in[gi]};
            end

            // Left out of reset so that a pin already high never looks like an edge.
            always_ff @(posedge CLOCK_50) begin
                sync_q <= sync_d;
            end

            assign pin_rise[gi] = ~sync_q[2] &  sync_q[1];
            assign pin_fall[gi] =  sync_q[2] & ~sync_q[1];
        end
    endgenerate

    logic bclk_fall;
    logic lrck_rise;
    logic lrck_fall;

    assign bclk_fall = pin_fall[0];
    assign lrck_rise = pin_rise[1];
    assign lrck_fall = pin_fall[1];

    // Frame storage: {left, right}. Tiny and read in the same cycle as the pop.
    logic [FW-1:0] mem_q [DEPTH];

    logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]      count_q, count_d;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  dacdat_q, dacdat_d;
    logic                  underflow_q, underflow_d;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic [FW-1:0]         rd_frame;

    assign write_ready = (count_q != FULL_CNT);
    assign empty       = (count_q == '0);
    assign push        = write & write_ready;
    assign rd_frame    = mem_q[rd_ptr_q];

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {writedata_left, writedata_right};
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        bit_cnt_d   = bit_cnt_q;
        dacdat_d    = dacdat_q;
        underflow_d = underflow_q;
        pop         = 1'b0;

        if (lrck_rise) begin
            // A new frame always starts here, whatever state we were in.
            state_d   = LEFT;
            bit_cnt_d = LAST_BIT;
            if (!empty) begin
                pop     = 1'b1;
                shift_d = rd_frame[FW-1:DATA_WIDTH];
                hold_d  = rd_frame[DATA_WIDTH-1:0];
            end else begin
                shift_d     = '0;
                hold_d      = '0;
                underflow_d = 1'b1;
            end
            dacdat_d = shift_d[DATA_WIDTH-1];
        end else if (lrck_fall && state_q == LEFT) begin
            state_d   = RIGHT;
            shift_d   = hold_q;
            bit_cnt_d = LAST_BIT;
            dacdat_d  = hold_q[DATA_WIDTH-1];
        end else if (bclk_fall && state_q != WAIT_SYNC) begin
            if (bit_cnt_q != '0) begin
                shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                dacdat_d  = shift_q[DATA_WIDTH-2];
                bit_cnt_d = bit_cnt_q - ONE_BIT;
            end else begin
                dacdat_d = 1'b0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= WAIT_SYNC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            bit_cnt_q   <= '0;
            dacdat_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            bit_cnt_q   <= bit_cnt_d;
            dacdat_q    <= dacdat_d;
            underflow_q <= underflow_d;
        end
    end

    assign AUD_DACDAT = dacdat_q;
    assign fifo_used  = count_q;
    assign underflow  = underflow_q;

endmodule
